// File: rtl/block_cipher_decrypt.sv
// ============================================================================
// block_cipher_decrypt : iterative 128-bit rotate/XOR block decryptor
// Revision : 1.0
// ============================================================================
`default_nettype none

module block_cipher_decrypt #(
   parameter int ROUNDS = 8,
   parameter int ROT    = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plaintext,
   output logic         busy
);

   localparam logic [3:0] c_cnt_init = 4'(ROUNDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         fsm_q, fsm_d;
   logic [127:0]   blk_q, blk_d;
   logic [127:0]   key_q, key_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           out_valid_q, out_valid_d;

   logic [6:0]     w_rk_amt;
   logic [127:0]   w_rk;
   logic [127:0]   w_mixed;
   logic [127:0]   w_round;

   // Round key is rebuilt each cycle from the latched key and the counter;
   // the 7-bit amount wraps 128 to 0 so rk[15] uses the unrotated key.
   always_comb begin
      w_rk_amt = ({3'd0, cnt_q} + 7'd1) << 3;
      w_rk     = (key_q << w_rk_amt) | (key_q >> (8'd128 - {1'b0, w_rk_amt}));
      w_rk     = w_rk ^ {124'd0, cnt_q};
      w_mixed  = blk_q ^ w_rk;
      w_round  = {w_mixed[ROT-1:0], w_mixed[127:ROT]};
   end

   always_comb begin
      fsm_d       = fsm_q;
      blk_d       = blk_q;
      key_d       = key_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid) begin
               blk_d = ciphertext;
               key_d = key;
               cnt_d = c_cnt_init;
               fsm_d = S_RUN;
            end
         end
         S_RUN: begin
            blk_d = w_round;
            if (cnt_q == 4'd0) begin
               fsm_d       = S_DONE;
               out_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            // Key material is wiped as soon as the result is consumed.
            if (out_ready) begin
               fsm_d       = S_IDLE;
               out_valid_d = 1'b0;
               blk_d       = '0;
               key_d       = '0;
            end
         end
         default: begin
            fsm_d       = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= S_IDLE;
         blk_q       <= '0;
         key_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         blk_q       <= blk_d;
         key_q       <= key_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (fsm_q == S_IDLE) && !rst;
   assign busy      = (fsm_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign plaintext = out_valid_q ? blk_q : 128'h0;

endmodule

`default_nettype wire

// File: tb/tb_block_cipher_decrypt.sv
// ============================================================================
// tb_block_cipher_decrypt : directed/self-checking bench for the decryptor
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_block_cipher_decrypt;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid, out_ready;
   logic [127:0] ct, key;
   logic         in_ready, out_valid, busy;
   logic [127:0] pt;

   logic         iv1, or1;
   logic [127:0] ct1, key1;
   logic         ir1, ov1, busy1;
   logic [127:0] pt1;

   int errors = 0;
   int checks = 0;

   block_cipher_decrypt dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .ciphertext(ct), .key(key),
      .out_valid(out_valid), .out_ready(out_ready),
      .plaintext(pt), .busy(busy)
   );

   block_cipher_decrypt #(.ROUNDS(1), .ROT(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(iv1), .in_ready(ir1),
      .ciphertext(ct1), .key(key1),
      .out_valid(ov1), .out_ready(or1),
      .plaintext(pt1), .busy(busy1)
   );

   function automatic logic [127:0] rotl128(input logic [127:0] x, input int n);
      int m;
      m = n % 128;
      if (m == 0) return x;
      return (x << m) | (x >> (128 - m));
   endfunction

   function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k,
                                            input int rounds, input int rot);
      logic [127:0] s;
      logic [127:0] rk;
      s = p;
      for (int r = 0; r < rounds; r++) begin
         rk = rotl128(k, 8 * (r + 1)) ^ {120'd0, r[7:0]};
         s  = rotl128(s, rot) ^ rk;
      end
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full block on the default instance; hold = DONE cycles with out_ready low.
   task automatic run_block(input logic [127:0] c, input logic [127:0] k,
                            input logic [127:0] exp, input int hold);
      int n;
      in_valid  = 1'b1;
      ct        = c;
      key       = k;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      ct       = ~c;
      key      = ~k;
      n        = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b1 || pt !== 128'h0) begin
            errors++;
            $display("FAIL run_flags: in_ready=%b busy=%b pt=%h expected 0 1 0", in_ready, busy, pt);
         end
         tick();
         n++;
      end
      checks++;
      if (n + 1 != 9) begin
         errors++;
         $display("FAIL latency: got %0d cycles expected 9", n + 1);
      end
      for (int i = 0; i < hold; i++) begin
         checks++;
         if (out_valid !== 1'b1 || pt !== exp || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold: out_valid=%b pt=%h expected 1 %h", out_valid, pt, exp);
         end
         tick();
      end
      checks++;
      if (pt !== exp) begin
         errors++;
         $display("FAIL plaintext: got %h expected %h", pt, exp);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || pt !== 128'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_handshake: out_valid=%b pt=%h in_ready=%b busy=%b expected 0 0 1 0",
                  out_valid, pt, in_ready, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; ct = '1; key = '1;
      iv1 = 1'b1; or1 = 1'b1; ct1 = '1; key1 = '1;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || pt !== 128'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b pt=%h busy=%b expected 0 0 0 0",
                  in_ready, out_valid, pt, busy);
      end
      checks++;
      if (ir1 !== 1'b0 || ov1 !== 1'b0 || pt1 !== 128'h0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state_small: in_ready=%b out_valid=%b busy=%b expected 0 0 0", ir1, ov1, busy1);
      end
      in_valid = 1'b0; out_ready = 1'b0; iv1 = 1'b0; or1 = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || ir1 !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: in_ready=%b/%b expected 1/1", in_ready, ir1);
      end
   endtask

   task automatic small_vector(input logic [127:0] c, input logic [127:0] k,
                               input logic [127:0] exp);
      int n;
      iv1 = 1'b1; ct1 = c; key1 = k;
      tick();
      iv1 = 1'b0;
      n = 0;
      while (ov1 !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (n + 1 != 2) begin
         errors++;
         $display("FAIL small_latency: got %0d expected 2", n + 1);
      end
      checks++;
      if (pt1 !== exp) begin
         errors++;
         $display("FAIL small_plaintext: got %h expected %h", pt1, exp);
      end
      or1 = 1'b1;
      tick();
      or1 = 1'b0;
      checks++;
      if (ov1 !== 1'b0 || pt1 !== 128'h0 || ir1 !== 1'b1) begin
         errors++;
         $display("FAIL small_release: out_valid=%b pt=%h in_ready=%b expected 0 0 1", ov1, pt1, ir1);
      end
   endtask

   task automatic test_small();
      small_vector(128'h1, 128'h0, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
      small_vector(128'h101, 128'h1, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
   endtask

   task automatic test_random();
      logic [127:0] p, k;
      for (int i = 0; i < 200; i++) begin
         p = rnd128();
         k = rnd128();
         run_block(encrypt(p, k, 8, 13), k, p, 0);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] p, k;
      p = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      k = 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100;
      run_block(encrypt(p, k, 8, 13), k, p, 20);
   endtask

   task automatic test_reset_mid_run();
      logic seen;
      logic [127:0] p, k;
      in_valid = 1'b1; ct = rnd128(); key = rnd128();
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || pt !== 128'h0) begin
         errors++;
         $display("FAIL abort: busy=%b out_valid=%b pt=%h expected 0 0 0", busy, out_valid, pt);
      end
      rst = 1'b0;
      out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid === 1'b1) seen = 1'b1;
         tick();
      end
      out_ready = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_output: out_valid seen=%b expected 0", seen);
      end
      p = rnd128();
      k = rnd128();
      run_block(encrypt(p, k, 8, 13), k, p, 0);
   endtask

   task automatic test_back_to_back_ignore();
      logic [127:0] p, k, exp_p;
      int n, hs;
      p = 128'hdead_beef_cafe_f00d_1234_5678_9abc_def0;
      k = 128'h8899_aabb_ccdd_eeff_0011_2233_4455_6677;
      exp_p = p;
      in_valid = 1'b1; ct = encrypt(p, k, 8, 13); key = k;
      tick();
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
         in_valid = 1'b1;
         ct  = rnd128();
         key = rnd128();
         tick();
         n++;
      end
      in_valid  = 1'b0;
      checks++;
      if (pt !== exp_p) begin
         errors++;
         $display("FAIL ignore_plaintext: got %h expected %h", pt, exp_p);
      end
      hs = (out_valid === 1'b1) ? 1 : 0;
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid === 1'b1) hs++;
      end
      out_ready = 1'b0;
      checks++;
      if (hs != 1) begin
         errors++;
         $display("FAIL ignore_handshakes: got %0d expected 1", hs);
      end
   endtask

   initial begin
      test_reset();
      test_small();
      test_random();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back_ignore();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
